// File: rtl/lector_tablero_if.sv
// Board-reader bus: start request, cell select/data port and result outputs.
// Latency: n/a (signal bundle only).
// Backpressure: none; the reader ignores starts while busy.
interface lector_tablero_if;
    logic       iniciar;
    logic [3:0] sel_celda;
    logic [5:0] dato_celda;
    logic       ocupado;
    logic       listo;
    logic [1:0] resultado;
    logic [2:0] linea_ganadora;
    logic       error_celda;

    // Game-logic side: requests scans and supplies the selected cell value.
    modport master (
        output iniciar, dato_celda,
        input  sel_celda, ocupado, listo, resultado, linea_ganadora, error_celda
    );

    // Reader side.
    modport slave (
        input  iniciar, dato_celda,
        output sel_celda, ocupado, listo, resultado, linea_ganadora, error_celda
    );
endinterface

// File: rtl/lector_tablero.sv
// Tic-tac-toe board reader: scans 9 cells, evaluates 8 lines, reports result.
// Latency: fixed 18 cycles from the start edge to the listo pulse; 19-cycle period.
// Backpressure: none; iniciar while busy is dropped, dato_celda must be valid same cycle.
module lector_tablero (
    input  logic              clk,
    input  logic              reset,
    lector_tablero_if.slave   bus
);
    typedef enum logic [1:0] {REPOSO, LEER, EVALUAR, FIN} estado_t;

    estado_t    estado;
    logic [3:0] cnt_celda;
    logic [2:0] cnt_linea;
    logic [1:0] tablero [9];
    logic       error_int;
    logic       hay_ganador;
    logic [1:0] ganador;
    logic [2:0] linea_lat;

    logic [3:0] sel_r;
    logic       ocupado_r;
    logic       listo_r;
    logic [1:0] resultado_r;
    logic [2:0] linea_r;
    logic       error_celda_r;

    logic [1:0] codigo;
    logic [1:0] codigo_limpio;
    logic       unused_bits;
    logic [3:0] ia, ib, ic;
    logic [1:0] ca, cb, cc;
    logic       gana;
    logic       lleno;

    // Only the occupant field matters; the upper bits belong to the game logic.
    assign codigo        = bus.dato_celda[1:0];
    assign codigo_limpio = (codigo == 2'b11) ? 2'b00 : codigo;
    assign unused_bits   = ^bus.dato_celda[5:2];

    // Cell indices of the line currently under evaluation.
    always_comb begin
        ia = 4'd0; ib = 4'd1; ic = 4'd2;
        case (cnt_linea)
            3'd0: begin ia = 4'd0; ib = 4'd1; ic = 4'd2; end
            3'd1: begin ia = 4'd3; ib = 4'd4; ic = 4'd5; end
            3'd2: begin ia = 4'd6; ib = 4'd7; ic = 4'd8; end
            3'd3: begin ia = 4'd0; ib = 4'd3; ic = 4'd6; end
            3'd4: begin ia = 4'd1; ib = 4'd4; ic = 4'd7; end
            3'd5: begin ia = 4'd2; ib = 4'd5; ic = 4'd8; end
            3'd6: begin ia = 4'd0; ib = 4'd4; ic = 4'd8; end
            default: begin ia = 4'd2; ib = 4'd4; ic = 4'd6; end
        endcase
    end

    assign ca   = tablero[ia];
    assign cb   = tablero[ib];
    assign cc   = tablero[ic];
    assign gana = (ca != 2'b00) && (ca == cb) && (ca == cc);

    // Board is full when no stored cell is empty (invalid codes were stored as empty).
    always_comb begin
        lleno = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (tablero[i] == 2'b00) lleno = 1'b0;
        end
    end

    // Scan/evaluate sequencer with registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            estado        <= REPOSO;
            cnt_celda     <= 4'd0;
            cnt_linea     <= 3'd0;
            for (int i = 0; i < 9; i++) tablero[i] <= 2'b00;
            error_int     <= 1'b0;
            hay_ganador   <= 1'b0;
            ganador       <= 2'b00;
            linea_lat     <= 3'd0;
            sel_r         <= 4'd0;
            ocupado_r     <= 1'b0;
            listo_r       <= 1'b0;
            resultado_r   <= 2'b00;
            linea_r       <= 3'd0;
            error_celda_r <= 1'b0;
        end else begin
            case (estado)
                REPOSO: begin
                    listo_r <= 1'b0;
                    sel_r   <= 4'd0;
                    if (bus.iniciar) begin
                        estado      <= LEER;
                        cnt_celda   <= 4'd0;
                        ocupado_r   <= 1'b1;
                        error_int   <= 1'b0;
                        hay_ganador <= 1'b0;
                        ganador     <= 2'b00;
                        linea_lat   <= 3'd0;
                    end
                end
                LEER: begin
                    tablero[cnt_celda] <= codigo_limpio;
                    if (codigo == 2'b11) error_int <= 1'b1;
                    if (cnt_celda == 4'd8) begin
                        estado    <= EVALUAR;
                        cnt_linea <= 3'd0;
                        sel_r     <= 4'd0;
                    end else begin
                        cnt_celda <= cnt_celda + 4'd1;
                        sel_r     <= cnt_celda + 4'd1;
                    end
                end
                EVALUAR: begin
                    // First winning line sticks; later ones are ignored.
                    if (gana && !hay_ganador) begin
                        hay_ganador <= 1'b1;
                        ganador     <= ca;
                        linea_lat   <= cnt_linea;
                    end
                    if (cnt_linea == 3'd7) begin
                        // Results are loaded as FIN is entered so they show with listo.
                        estado        <= FIN;
                        listo_r       <= 1'b1;
                        error_celda_r <= error_int;
                        if (hay_ganador) begin
                            resultado_r <= ganador;
                            linea_r     <= linea_lat;
                        end else if (gana) begin
                            resultado_r <= ca;
                            linea_r     <= cnt_linea;
                        end else if (lleno) begin
                            resultado_r <= 2'b11;
                            linea_r     <= 3'd0;
                        end else begin
                            resultado_r <= 2'b00;
                            linea_r     <= 3'd0;
                        end
                    end else begin
                        cnt_linea <= cnt_linea + 3'd1;
                    end
                end
                default: begin
                    listo_r   <= 1'b0;
                    ocupado_r <= 1'b0;
                    estado    <= REPOSO;
                end
            endcase
        end
    end

    assign bus.sel_celda      = sel_r;
    assign bus.ocupado        = ocupado_r;
    assign bus.listo          = listo_r;
    assign bus.resultado      = resultado_r;
    assign bus.linea_ganadora = linea_r;
    assign bus.error_celda    = error_celda_r;
endmodule

// File: tb/tb_lector_tablero.sv
// Bench for lector_tablero: directed vector table, corner sequences, random boards vs model.
// Latency: checks the 18-cycle start-to-listo latency and 19-cycle held-start period.
// Backpressure: checks that a start during a busy scan is dropped.
module tb_lector_tablero;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;
    logic [5:0] celdas [9];

    lector_tablero_if bus ();

    lector_tablero dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // External combinational cell mux.
    always_comb begin
        bus.dato_celda = 6'h00;
        if (bus.sel_celda < 4'd9) bus.dato_celda = celdas[bus.sel_celda];
    end

    int lm [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                      '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

    typedef struct {
        logic [53:0] tab;
        logic [1:0]  res;
        logic [2:0]  lin;
        logic        err;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [53:0] mk(input logic [5:0] c0, c1, c2, c3, c4, c5, c6, c7, c8);
        return {c8, c7, c6, c5, c4, c3, c2, c1, c0};
    endfunction

    task automatic cargar(input logic [53:0] t);
        for (int i = 0; i < 9; i++) celdas[i] = t[6*i +: 6];
    endtask

    // Reference: rules of tic-tac-toe applied directly to the cell list.
    function automatic logic [5:0] modelo(input logic [53:0] t);
        logic [1:0] occ [9];
        logic       err = 1'b0;
        logic       full = 1'b1;
        logic [1:0] res = 2'b00;
        logic [2:0] lin = 3'd0;
        bit         found = 0;
        for (int i = 0; i < 9; i++) begin
            occ[i] = t[6*i +: 2];
            if (occ[i] == 2'b11) begin err = 1'b1; occ[i] = 2'b00; end
            if (occ[i] == 2'b00) full = 1'b0;
        end
        for (int l = 0; l < 8; l++) begin
            if (!found && occ[lm[l][0]] != 2'b00 &&
                occ[lm[l][0]] == occ[lm[l][1]] && occ[lm[l][0]] == occ[lm[l][2]]) begin
                found = 1;
                res   = occ[lm[l][0]];
                lin   = 3'(l);
            end
        end
        if (!found && full) res = 2'b11;
        return {err, res, lin};
    endfunction

    function automatic logic [11:0] salidas();
        return {bus.sel_celda, bus.ocupado, bus.listo, bus.resultado, bus.linea_ganadora, bus.error_celda};
    endfunction

    // Pulses iniciar, follows the scan, returns at the listo cycle (lat = negedges after start edge).
    task automatic do_scan(output int lat, output bit sel_ok);
        lat = 0;
        sel_ok = 1;
        @(negedge clk);
        bus.iniciar = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            bus.iniciar = 1'b0;
            if (n <= 9 && (bus.sel_celda !== 4'(n - 1) || bus.ocupado !== 1'b1)) sel_ok = 0;
            if (bus.listo === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int  lat;
        bit  sel_ok;
        int  nlisto;
        int  primero;
        int  segundo;
        logic [53:0] t;
        logic [5:0]  m;
        logic [1:0]  res_prev;

        vecs[0] = '{mk(6'h01,6'h01,6'h01,0,0,0,0,0,0), 2'b01, 3'd0, 1'b0};
        vecs[1] = '{mk(0,0,6'h3E,0,6'h3E,0,6'h3E,0,0), 2'b10, 3'd7, 1'b0};
        vecs[2] = '{mk(1,2,1,1,2,2,2,1,1),             2'b11, 3'd0, 1'b0};
        vecs[3] = '{mk(0,0,0,0,6'h03,0,0,0,0),         2'b00, 3'd0, 1'b1};
        vecs[4] = '{mk(2,2,2,1,1,1,0,0,0),             2'b10, 3'd0, 1'b0};
        vecs[5] = '{mk(0,0,0,0,0,0,0,0,0),             2'b00, 3'd0, 1'b0};
        vecs[6] = '{mk(0,6'h05,0,0,6'h05,0,0,6'h05,0), 2'b01, 3'd4, 1'b0};
        vecs[7] = '{mk(2,6'h3F,0,0,2,0,0,0,2),         2'b10, 3'd6, 1'b1};

        bus.iniciar = 1'b0;
        for (int i = 0; i < 9; i++) celdas[i] = 6'h00;

        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset_outputs", 32'(salidas()), 32'h0);
        repeat (5) @(negedge clk);
        chk("idle_ocupado", 32'(bus.ocupado), 32'h0);

        for (int v = 0; v < 8; v++) begin
            cargar(vecs[v].tab);
            do_scan(lat, sel_ok);
            chk($sformatf("vec%0d_latency", v), 32'(lat), 32'd18);
            chk($sformatf("vec%0d_sel_seq", v), 32'(sel_ok), 32'd1);
            chk($sformatf("vec%0d_resultado", v), 32'(bus.resultado), 32'(vecs[v].res));
            chk($sformatf("vec%0d_linea", v), 32'(bus.linea_ganadora), 32'(vecs[v].lin));
            chk($sformatf("vec%0d_error", v), 32'(bus.error_celda), 32'(vecs[v].err));
            @(negedge clk);
            chk($sformatf("vec%0d_after", v), 32'({bus.ocupado, bus.listo}), 32'h0);
        end

        // Results hold while idle.
        res_prev = bus.resultado;
        repeat (4) @(negedge clk);
        chk("result_hold", 32'(bus.resultado), 32'(res_prev));

        // Reset mid-scan at cell 5.
        cargar(vecs[0].tab);
        @(negedge clk);
        bus.iniciar = 1'b1;
        @(negedge clk);
        bus.iniciar = 1'b0;
        for (int n = 0; n < 20 && bus.sel_celda !== 4'd5; n++) @(negedge clk);
        chk("midscan_sel5", 32'(bus.sel_celda), 32'd5);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("midscan_reset_outputs", 32'(salidas()), 32'h0);
        nlisto = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.listo === 1'b1) nlisto++;
        end
        chk("midscan_no_listo", 32'(nlisto), 32'd0);

        // Start while busy is dropped.
        cargar(vecs[1].tab);
        @(negedge clk);
        bus.iniciar = 1'b1;
        @(posedge clk);
        nlisto = 0;
        primero = 0;
        for (int n = 1; n <= 45; n++) begin
            @(negedge clk);
            bus.iniciar = (n == 12) ? 1'b1 : 1'b0;
            if (bus.listo === 1'b1) begin
                nlisto++;
                if (primero == 0) primero = n;
            end
        end
        chk("busy_listo_count", 32'(nlisto), 32'd1);
        chk("busy_listo_latency", 32'(primero), 32'd18);

        // Held start gives one scan every 19 cycles.
        cargar(vecs[2].tab);
        @(negedge clk);
        bus.iniciar = 1'b1;
        @(posedge clk);
        primero = 0;
        segundo = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.listo === 1'b1) begin
                if (primero == 0) primero = n;
                else if (segundo == 0) segundo = n;
            end
        end
        bus.iniciar = 1'b0;
        chk("held_first", 32'(primero), 32'd18);
        chk("held_period", 32'(segundo - primero), 32'd19);
        for (int n = 0; n < 40 && bus.ocupado !== 1'b0; n++) @(negedge clk);
        chk("held_back_idle", 32'(bus.ocupado), 32'h0);

        // Random boards against the model.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < 9; i++) begin
                int k;
                logic [1:0] o;
                k = $urandom_range(0, 9);
                o = (k < 3) ? 2'b00 : (k < 6) ? 2'b01 : (k < 9) ? 2'b10 : 2'b11;
                t[6*i +: 6] = {4'($urandom_range(0, 15)), o};
            end
            cargar(t);
            m = modelo(t);
            do_scan(lat, sel_ok);
            chk($sformatf("rnd%0d_latency", r), 32'(lat), 32'd18);
            chk($sformatf("rnd%0d_result", r),
                32'({bus.error_celda, bus.resultado, bus.linea_ganadora}), 32'(m));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lector_tablero.md
# lector_tablero

Board reader and result evaluator for the tic-tac-toe datapath. The cell registers are written by the game logic and present their 6-bit values. This block is the read side of that interface. On request it scans all nine cell registers through a select/data port, one cell per clock. It then checks the eight winning lines one per clock and reports the result: game continues, X wins, O wins, or draw. It also reports the winning line index and whether any cell held an invalid code.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  reset, synchronous, active-high.
- iniciar  in  1  start request; sampled only in REPOSO.
- sel_celda  out  4  index of the cell being read (0–8, row-major: 0 top-left, 8 bottom-right).
- dato_celda  in  6  value of the selected cell register.
  - Bits [1:0]: occupant. 00 empty, 01 X, 10 O, 11 invalid.
  - Bits [5:2]: ignored by this block.
  - Must be valid in the same cycle sel_celda is driven (combinational mux outside this block).
- ocupado  out  1  high from LEER through FIN inclusive.
- listo  out  1  one-cycle pulse; results valid from this cycle onward.
- resultado  out  2  00 continue, 01 X wins, 10 O wins, 11 draw.
- linea_ganadora  out  3  index of the winning line; 0 when there is no winner.
- error_celda  out  1  at least one cell read code 11 during the last scan.

## Operation
State machine states: REPOSO, LEER, EVALUAR, FIN.

- REPOSO
  - sel_celda = 0.
  - If iniciar = 1, go to LEER with the cell counter = 0.
- LEER
  - sel_celda = cell counter.
  - Each cycle, store dato_celda[1:0] into an internal 9×2 board image at that index.
  - Any code 11 is stored as 00 (empty) and sets the internal error flag.
  - After cell 8 is stored, go to EVALUAR with the line counter = 0.
- EVALUAR
  - One line per cycle, in order 0–7.
  - Line map:
    - 0: cells 0,1,2
    - 1: cells 3,4,5
    - 2: cells 6,7,8
    - 3: cells 0,3,6
    - 4: cells 1,4,7
    - 5: cells 2,5,8
    - 6: cells 0,4,8
    - 7: cells 2,4,6
  - A line wins when all three cells hold the same non-empty code.
  - The lowest-index winning line is latched; later winning lines are ignored, including lines won by the other player on an illegal board.
  - All 8 lines are always evaluated; there is no early exit.
  - After line 7, go to FIN.
- FIN
  - Assert listo for one cycle.
  - Update the result registers from the evaluation:
    - Winner found: resultado = winner's code, linea_ganadora = latched line.
    - No winner and all 9 stored cells non-empty: resultado = 11, linea_ganadora = 0.
    - Otherwise: resultado = 00, linea_ganadora = 0.
  - error_celda = internal error flag.
  - Next state: REPOSO.
- Result outputs hold their values until the next FIN.
- The internal error flag and the winner latch are cleared on entry to LEER.
- iniciar while ocupado = 1 is ignored; it is not queued.

## Timing
- Reset (synchronous, takes effect at the next edge with reset = 1):
  - State = REPOSO, counters = 0, board image cleared.
  - sel_celda = 0, ocupado = 0, listo = 0, resultado = 00, linea_ganadora = 0, error_celda = 0.
- Reset asserted mid-scan or mid-evaluation aborts the operation; no listo is produced.
- Let E be the edge where iniciar = 1 is sampled in REPOSO:
  - Cycles E+1 to E+9: LEER, with sel_celda = 0..8 and ocupado = 1.
  - Cycles E+10 to E+17: EVALUAR.
  - Cycle E+18: FIN, with listo = 1 and new results visible.
  - Cycle E+19: REPOSO, ocupado = 0.
  - Fixed latency of 18 cycles from the start edge to listo.
- iniciar held high continuously starts a new scan in the first REPOSO cycle after FIN. The period is 19 cycles per scan.
- dato_celda is sampled at the end of each LEER cycle. A change to a cell register already read does not affect the current scan.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset then idle:
  - Stimulus: hold reset 2 cycles, then release.
  - Required: all outputs 0; ocupado stays 0 with iniciar = 0.
- Row win:
  - Stimulus: cells 0,1,2 = 6'h01; all others 00; pulse iniciar.
  - Required: sel_celda steps 0..8; listo 18 cycles after the start edge; resultado = 01; linea_ganadora = 0; error_celda = 0.
- Anti-diagonal O win with upper bits set:
  - Stimulus: cells 2,4,6 = 6'h3E (occupant 10); others empty.
  - Required: resultado = 10; linea_ganadora = 7.
- Draw with no empty cell:
  - Stimulus: board X O X / X O O / O X X.
  - Required: resultado = 11; linea_ganadora = 0.
- Invalid code and illegal board:
  - First scan stimulus: cell 4 = 2'b11, others empty.
    - Required: resultado = 00; error_celda = 1.
  - Second scan stimulus: row 0 = O and row 1 = X.
    - Required: resultado = 10; linea_ganadora = 0; error_celda = 0.
- Reset mid-scan and busy start:
  - Stimulus: assert reset during LEER at sel_celda = 5.
    - Required: outputs at reset values next cycle; no listo.
  - Stimulus: re-start, then pulse iniciar again during EVALUAR.
    - Required: exactly one listo, 18 cycles after the first start edge.
